rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Consumes the synchronized system reset and distributes it to NUM_STAGES downstream domains, for example SDRAM controller, camera config, CNN core and VGA.
- Releases the domains one at a time, in index order. Each stage must report its init done before the next stage is released.
- Includes a per-stage timeout with bounded retry, and a software reset request that restarts the whole sequence.
- Sits directly after the reset synchronizer at the top level.

Parameters:
- NUM_STAGES, 4: number of sequenced reset domains (≥1).
- HOLD_CYC, 16: cycles all stage resets stay asserted before stage 0 is released (≥1).
- GAP_CYC, 8: idle cycles between stage i done and stage i+1 release (≥0).
- TIMEOUT_CYC, 65535: cycles allowed for stage_done[i] after release (≥1).
- MAX_RETRY, 3: failed sequence attempts allowed before the block enters FAULT (≥1).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- sw_rst_req, input, 1: single-cycle software request to re-run the sequence.
- stage_done, input, NUM_STAGES: per-domain init-done, level.
- stage_rst, output, NUM_STAGES: per-domain reset, active-high, registered.
- all_ready, output, 1: all stages released and done.
- cur_stage, output, max(1,$clog2(NUM_STAGES)): index of the stage being released or awaited.
- timeout_err, output, 1: sticky; at least one timeout has occurred since rst.
- fault, output, 1: retry budget exhausted.

Behaviour:
- Reset values (while rst=1): stage_rst all 1; all_ready 0; cur_stage 0; timeout_err 0; fault 0; retry count 0; state HOLD; counter 0.
- Cycle numbering: cycle 0 is the first cycle with rst=0. All outputs come from flops; there is no combinational input-to-output path.
- FSM states: HOLD, WAIT_DONE, GAP, READY, FAULT.
- HOLD:
  - stage_rst stays all 1 and the counter runs for HOLD_CYC cycles.
  - Then go to WAIT_DONE with cur_stage=0 and stage_rst[0]=0.
  - From rst, stage_rst[0] is first low in cycle HOLD_CYC.
- WAIT_DONE (stage i):
  - Only stage_done[i] is sampled. stage_done of unreleased stages is ignored.
  - stage_done[i] high in cycle k with i<NUM_STAGES-1: go to GAP.
    - stage_rst[i+1] is first low in cycle k+1+GAP_CYC.
    - cur_stage increments in the same cycle as that release.
  - stage_done[i] high in cycle k with i=NUM_STAGES-1: all_ready=1 from cycle k+1; go to READY.
  - Timeout: stage i released in cycle r and stage_done[i] low in cycles r..r+TIMEOUT_CYC-1. Then in cycle r+TIMEOUT_CYC:
    - stage_rst is all 1 and timeout_err=1; the retry count increments.
    - If the new count equals MAX_RETRY: go to FAULT, fault=1.
    - Otherwise: go to HOLD with cur_stage=0, and the full sequence restarts.
- GAP: counts GAP_CYC cycles. The stage_done inputs are ignored. GAP_CYC=0 releases the next stage the cycle after done.
- READY:
  - Holds all stage_rst=0 and all_ready=1.
  - Later deassertion of any stage_done is ignored. Domain health is not this block's concern.
- FAULT: stage_rst all 1, fault=1, all_ready=0. Only rst or sw_rst_req exits.
- sw_rst_req (any state, any cycle):
  - Highest priority; it beats a timeout or done in the same cycle.
  - Next cycle: state HOLD, stage_rst all 1, all_ready 0, fault 0, cur_stage 0, counter and retry count cleared.
  - timeout_err is not cleared; only rst clears it.
  - A request during HOLD restarts the HOLD count.
- Release-order invariant: stage_rst[j] is never 0 while stage_rst[j-1] is 1.
- Counter: a single shared counter, width $clog2 of max(HOLD_CYC, GAP_CYC, TIMEOUT_CYC)+1. It reloads on every state entry and never wraps within a state.
- Retry count width: $clog2(MAX_RETRY+1).

Decomposition:
- Package rst_seq_pkg: state enum (HOLD, WAIT_DONE, GAP, READY, FAULT), and a width helper function for the counter and cur_stage.
- No sub-module needed.
- Instantiate the existing two-flop synchronizer outside this block, one per asynchronous stage_done source.

Test Plan:
All scenarios use NUM_STAGES=3, HOLD_CYC=8, GAP_CYC=4, TIMEOUT_CYC=20, MAX_RETRY=2.
- Nominal:
  - Stimulus: stage_done[0] high at cycle 12; stage_done[1] 3 cycles after stage_rst[1] falls; stage_done[2] likewise.
  - Response: stage_rst[0] low at cycle 8; stage_rst[1] low at cycle 17; stage_rst[2] low 4+1 cycles after done[1]; all_ready 1 cycle after done[2]; timeout_err=0.
- Premature done:
  - Stimulus: stage_done all 1 from cycle 0.
  - Response: releases at cycles 8, 13, 18; all_ready at cycle 19; the invariant holds throughout.
- Single timeout:
  - Stimulus: stage_done[1] never asserts on the first pass; done normally on the second.
  - Response: stage_rst all 1 at release(1)+20; timeout_err=1 and stays 1; sequence restarts with a HOLD of 8; all_ready asserts; fault=0.
- Fault:
  - Stimulus: stage_done[0] tied 0.
  - Response: two timeouts at cycles 28 and 56; fault=1 from cycle 56; stage_rst stays all 1 indefinitely.
- sw_rst_req priority:
  - Stimulus: pulse sw_rst_req in READY; separately, pulse it in the same cycle as a timeout in FAULT-bound retry 2.
  - Response: next cycle stage_rst all 1, all_ready=0; no transition to FAULT; retry count 0; re-release of stage 0 8 cycles later; timeout_err unchanged.
- Reset mid-sequence:
  - Stimulus: assert rst during GAP after stage 0 done.
  - Response: next cycle all outputs at reset values, including timeout_err=0; a clean sequence follows once rst is released.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and width helpers for the reset sequencer.
// Holds the FSM state encoding and sizing functions for counters/indices.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_DONE,
    GAP,
    READY,
    FAULT
  } state_e;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int unsigned cw(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases downstream reset domains one at a time in index
// order, with per-stage timeout, bounded retry and software restart.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY   = 3,
  localparam int unsigned SW = cw(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic [SW-1:0]         cur_stage,
  output logic                  timeout_err,
  output logic                  fault
);

  localparam int unsigned CNT_MAX =
    max3(HOLD_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam int unsigned CW = cw(CNT_MAX + 1);
  localparam int unsigned RW = cw(MAX_RETRY + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] LAST_STG = SW'(NUM_STAGES - 1);
  localparam logic [RW-1:0] RTY_LIM = RW'(MAX_RETRY);
  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         cur_q, cur_d;
  logic [RW-1:0]         rty_q, rty_d;
  logic [NUM_STAGES-1:0] srst_q, srst_d;
  logic                  rdy_q, rdy_d;
  logic                  terr_q, terr_d;
  logic                  flt_q, flt_d;
  logic [SW-1:0]         nxt;
  logic [RW-1:0]         rty_inc;

  assign nxt     = cur_q + SW'(1);
  assign rty_inc = rty_q + RW'(1);

  // Next-state logic; a software request overrides every other event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    cur_d   = cur_q;
    rty_d   = rty_q;
    srst_d  = srst_q;
    rdy_d   = rdy_q;
    terr_d  = terr_q;
    flt_d   = flt_q;
    if (sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      cur_d   = '0;
      rty_d   = '0;
      srst_d  = '1;
      rdy_d   = 1'b0;
      flt_d   = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_DONE;
            cnt_d   = '0;
            cur_d   = '0;
            srst_d  = srst_q & ~ONE;
          end
        end
        WAIT_DONE: begin
          if (stage_done[cur_q]) begin
            cnt_d = '0;
            if (cur_q == LAST_STG) begin
              state_d = READY;
              rdy_d   = 1'b1;
            end else if (GAP_CYC == 0) begin
              cur_d  = nxt;
              srst_d = srst_q & ~(ONE << nxt);
            end else begin
              state_d = GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            cnt_d  = '0;
            cur_d  = '0;
            srst_d = '1;
            terr_d = 1'b1;
            rty_d  = rty_inc;
            if (rty_inc == RTY_LIM) begin
              state_d = FAULT;
              flt_d   = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = WAIT_DONE;
            cnt_d   = '0;
            cur_d   = nxt;
            srst_d  = srst_q & ~(ONE << nxt);
          end
        end
        READY: cnt_d = cnt_q;
        FAULT: cnt_d = cnt_q;
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          cur_d   = '0;
          srst_d  = '1;
          rdy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      cur_q   <= '0;
      rty_q   <= '0;
      srst_q  <= '1;
      rdy_q   <= 1'b0;
      terr_q  <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rty_q   <= rty_d;
      srst_q  <= srst_d;
      rdy_q   <= rdy_d;
      terr_q  <= terr_d;
      flt_q   <= flt_d;
    end
  end

  assign stage_rst   = srst_q;
  assign all_ready   = rdy_q;
  assign cur_stage   = cur_q;
  assign timeout_err = terr_q;
  assign fault       = flt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed scoreboard bench for rst_seq_ctrl.
// Expected output snapshots are queued per cycle and checked on arrival.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic [2:0] stage_done;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic [1:0] cur_stage;
  logic       timeout_err;
  logic       fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         c;
    logic [7:0] v;
  } exp_t;

  exp_t  sb[$];
  string tags[$];

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_STAGES (3),
    .HOLD_CYC   (8),
    .GAP_CYC    (4),
    .TIMEOUT_CYC(20),
    .MAX_RETRY  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .stage_done (stage_done),
    .stage_rst  (stage_rst),
    .all_ready  (all_ready),
    .cur_stage  (cur_stage),
    .timeout_err(timeout_err),
    .fault      (fault)
  );

  task automatic want(
    input string      t,
    input int         c,
    input logic [2:0] r,
    input logic       a,
    input logic [1:0] s,
    input logic       te,
    input logic       f
  );
    exp_t e;
    e.c = c;
    e.v = {r, a, s, te, f};
    sb.push_back(e);
    tags.push_back(t);
  endtask

  task automatic check_due();
    exp_t       e;
    string      t;
    logic [7:0] obs;
    obs = {stage_rst, all_ready, cur_stage, timeout_err, fault};
    for (int j = 1; j < 3; j++) begin
      total++;
      assert (!(stage_rst[j] === 1'b0 && stage_rst[j-1] !== 1'b0))
      else begin
        bad++;
        $error("FAIL order cyc=%0d stage_rst=%b", cyc, stage_rst);
      end
    end
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      t = tags.pop_front();
      total++;
      assert (e.c == cyc && obs === e.v)
      else begin
        bad++;
        $error({"FAIL %s cyc=%0d/%0d got rst=%b rdy=%b cur=%0d",
                " terr=%b flt=%b exp rst=%b rdy=%b cur=%0d",
                " terr=%b flt=%b"},
               t, cyc, e.c, obs[7:5], obs[4], obs[3:2], obs[1],
               obs[0], e.v[7:5], e.v[4], e.v[3:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_due();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
  endtask

  task automatic begin_run(input logic [2:0] d);
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL pending got=%0d exp=0", sb.size());
      sb.delete();
      tags.delete();
    end
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    stage_done = d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    want("reset", 0, 3'b111, 0, 0, 0, 0);
    check_due();
  endtask

  initial begin
    // Nominal sequence
    begin_run(3'b000);
    want("n_hold7", 7,  3'b111, 0, 0, 0, 0);
    want("n_rel0",  8,  3'b110, 0, 0, 0, 0);
    want("n_gap",   16, 3'b110, 0, 0, 0, 0);
    want("n_rel1",  17, 3'b100, 0, 1, 0, 0);
    want("n_pre2",  24, 3'b100, 0, 1, 0, 0);
    want("n_rel2",  25, 3'b000, 0, 2, 0, 0);
    want("n_nordy", 28, 3'b000, 0, 2, 0, 0);
    want("n_rdy",   29, 3'b000, 1, 2, 0, 0);
    want("n_keep",  33, 3'b000, 1, 2, 0, 0);
    run_to(12); stage_done = 3'b001;
    run_to(20); stage_done = 3'b011;
    run_to(28); stage_done = 3'b111;
    run_to(30); stage_done = 3'b000;
    run_to(34);

    // Premature done
    begin_run(3'b111);
    want("p_rel0", 8,  3'b110, 0, 0, 0, 0);
    want("p_gap",  12, 3'b110, 0, 0, 0, 0);
    want("p_rel1", 13, 3'b100, 0, 1, 0, 0);
    want("p_pre2", 17, 3'b100, 0, 1, 0, 0);
    want("p_rel2", 18, 3'b000, 0, 2, 0, 0);
    want("p_rdy",  19, 3'b000, 1, 2, 0, 0);
    run_to(22);

    // Single timeout on stage 1
    begin_run(3'b000);
    want("t_pre",   36, 3'b100, 0, 1, 0, 0);
    want("t_to",    37, 3'b111, 0, 0, 1, 0);
    want("t_hold",  44, 3'b111, 0, 0, 1, 0);
    want("t_rel0",  45, 3'b110, 0, 0, 1, 0);
    want("t_rel1",  50, 3'b100, 0, 1, 1, 0);
    want("t_rel2",  58, 3'b000, 0, 2, 1, 0);
    want("t_rdy",   62, 3'b000, 1, 2, 1, 0);
    run_to(12); stage_done = 3'b001;
    run_to(53); stage_done = 3'b011;
    run_to(61); stage_done = 3'b111;
    run_to(64);

    // Fault, then software restart, then restart from READY
    begin_run(3'b000);
    want("f_pre",   27, 3'b110, 0, 0, 0, 0);
    want("f_to1",   28, 3'b111, 0, 0, 1, 0);
    want("f_hold",  35, 3'b111, 0, 0, 1, 0);
    want("f_rel",   36, 3'b110, 0, 0, 1, 0);
    want("f_pre2",  55, 3'b110, 0, 0, 1, 0);
    want("f_to2",   56, 3'b111, 0, 0, 1, 1);
    want("f_stay",  81, 3'b111, 0, 0, 1, 1);
    want("s_clr",   82, 3'b111, 0, 0, 1, 0);
    want("s_hold",  89, 3'b111, 0, 0, 1, 0);
    want("s_rel0",  90, 3'b110, 0, 0, 1, 0);
    want("s_rel1",  95, 3'b100, 0, 1, 1, 0);
    want("s_rel2",  100, 3'b000, 0, 2, 1, 0);
    want("s_rdy",   101, 3'b000, 1, 2, 1, 0);
    want("s_keep",  104, 3'b000, 1, 2, 1, 0);
    want("r_clr",   106, 3'b111, 0, 0, 1, 0);
    want("r_hold",  113, 3'b111, 0, 0, 1, 0);
    want("r_rel0",  114, 3'b110, 0, 0, 1, 0);
    run_to(60); stage_done = 3'b111;
    run_to(81); pulse_sw();
    run_to(102); stage_done = 3'b000;
    run_to(105); pulse_sw();
    run_to(115);

    // Software request coincident with the faulting timeout
    begin_run(3'b000);
    want("c_pre",   55, 3'b110, 0, 0, 1, 0);
    want("c_sw",    56, 3'b111, 0, 0, 1, 0);
    want("c_hold",  63, 3'b111, 0, 0, 1, 0);
    want("c_rel0",  64, 3'b110, 0, 0, 1, 0);
    want("c_to1",   84, 3'b111, 0, 0, 1, 0);
    want("c_rel0b", 92, 3'b110, 0, 0, 1, 0);
    want("c_flt",   112, 3'b111, 0, 0, 1, 1);
    want("m_clr",   114, 3'b111, 0, 0, 1, 0);
    want("m_rel0",  122, 3'b110, 0, 0, 1, 0);
    want("m_gap",   126, 3'b110, 0, 0, 1, 0);
    want("m_rst",   127, 3'b111, 0, 0, 0, 0);
    run_to(55); pulse_sw();
    run_to(113); pulse_sw();
    run_to(124); stage_done = 3'b001;
    run_to(126);
    rst = 1'b1;
    tick();

    // Clean sequence after mid-sequence reset
    begin_run(3'b111);
    want("k_rel0", 8,  3'b110, 0, 0, 0, 0);
    want("k_rel1", 13, 3'b100, 0, 1, 0, 0);
    want("k_rel2", 18, 3'b000, 0, 2, 0, 0);
    want("k_rdy",  19, 3'b000, 1, 2, 0, 0);
    run_to(22);

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL pending got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
